// File: rtl/ram_arbiter_pkg.sv
// Shared types for the round-robin RAM arbiter: FSM state encoding and the
// per-command read/write flag.
package ram_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StReadWait,
    StResp
  } state_e;

  typedef logic cmd_t;

  localparam cmd_t CmdRead  = 1'b0;
  localparam cmd_t CmdWrite = 1'b1;

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester handshake bus plus the RAM command/data pins of the arbiter.
// master = requesters and RAM side, slave = the arbiter itself.
interface ram_arbiter_if #(
  parameter int unsigned nreq      = 2,
  parameter int unsigned addrwidth = 8,
  parameter int unsigned datawidth = 8
);

  logic [nreq-1:0]           req_valid;
  logic [nreq-1:0]           req_ready;
  logic [nreq-1:0]           req_we;
  logic [nreq*addrwidth-1:0] req_addr;
  logic [nreq*datawidth-1:0] req_wdata;
  logic [nreq-1:0]           rsp_valid;
  logic [datawidth-1:0]      rsp_rdata;
  logic [addrwidth-1:0]      ram_address;
  logic                      ram_ren;
  logic                      ram_wen;
  logic [datawidth-1:0]      ram_data_in;
  logic [datawidth-1:0]      ram_data_out;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, ram_data_out,
    input  req_ready, rsp_valid, rsp_rdata, ram_address, ram_ren, ram_wen, ram_data_in
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, ram_data_out,
    output req_ready, rsp_valid, rsp_rdata, ram_address, ram_ren, ram_wen, ram_data_in
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr_i,
// wrapping modulo nreq. Pointer state lives in the caller.
module rr_arbiter #(
  parameter int unsigned nreq = 2,
  localparam int unsigned IdxW = $clog2(nreq)
) (
  input  logic [nreq-1:0] req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [nreq-1:0] gnt_o,
  output logic [IdxW-1:0] idx_o
);

  int unsigned cand;
  logic        found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = 0;
    for (int unsigned off = 0; off < nreq; off++) begin
      cand = (32'(ptr_i) + off) % nreq;
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = IdxW'(cand);
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port RAM among nreq requesters: round-robin grant in idle,
// one-cycle ren/wen strobe, optional read wait, then a one-cycle response pulse.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned addrwidth = 8,
  parameter int unsigned datawidth = 8,
  parameter int unsigned nreq      = 2
) (
  input logic         clk,
  input logic         rst,
  ram_arbiter_if.slave bus
);

  localparam int unsigned IdxW = $clog2(nreq);

  state_e               state_q, state_d;
  logic [IdxW-1:0]      ptr_q, ptr_d;
  logic [IdxW-1:0]      owner_q;
  cmd_t                 cmd_q;
  logic                 ren_q, wen_q;
  logic [addrwidth-1:0] addr_q;
  logic [datawidth-1:0] wdata_q;
  logic [datawidth-1:0] rdata_q;

  logic [nreq-1:0]      win_gnt;
  logic [IdxW-1:0]      win_idx;
  logic                 accept;
  cmd_t                 win_cmd;
  logic [addrwidth-1:0] win_addr;
  logic [datawidth-1:0] win_wdata;

  rr_arbiter #(
    .nreq (nreq)
  ) u_rr_arbiter (
    .req_i (bus.req_valid),
    .ptr_i (ptr_q),
    .gnt_o (win_gnt),
    .idx_o (win_idx)
  );

  // req_valid never depends on req_ready, so any valid in idle is an accept.
  assign accept = (state_q == StIdle) && (|bus.req_valid);
  assign ptr_d  = (win_idx == IdxW'(nreq - 1)) ? '0 : win_idx + 1'b1;

  // One-hot mux of the winning requester's command fields.
  always_comb begin
    win_cmd   = CmdRead;
    win_addr  = '0;
    win_wdata = '0;
    for (int unsigned i = 0; i < nreq; i++) begin
      if (win_gnt[i]) begin
        win_cmd   = bus.req_we[i];
        win_addr  = bus.req_addr[i*addrwidth +: addrwidth];
        win_wdata = bus.req_wdata[i*datawidth +: datawidth];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    unique case (state_q)
      StIdle: begin
        bus.req_ready = win_gnt;
        if (accept) state_d = StAccess;
      end
      StAccess:   state_d = (cmd_q == CmdWrite) ? StResp : StReadWait;
      StReadWait: state_d = StResp;
      StResp: begin
        bus.rsp_valid[owner_q] = 1'b1;
        state_d                = StIdle;
      end
      default:    state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      owner_q <= '0;
      cmd_q   <= CmdRead;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      if (accept) begin
        ptr_q   <= ptr_d;
        owner_q <= win_idx;
        cmd_q   <= win_cmd;
        addr_q  <= win_addr;
        wdata_q <= win_wdata;
        ren_q   <= (win_cmd == CmdRead);
        wen_q   <= (win_cmd == CmdWrite);
      end
      if (state_q == StReadWait) rdata_q <= bus.ram_data_out;
    end
  end

  assign bus.ram_address = addr_q;
  assign bus.ram_data_in = wdata_q;
  assign bus.ram_ren     = ren_q;
  assign bus.ram_wen     = wen_q;
  assign bus.rsp_rdata   = rdata_q;

endmodule
